// File: rtl/regfile_access_arbiter_if.sv
// Requester-side bundle for the register-file access arbiter: request fields
// flow master -> slave, ready/response flow back.
interface regfile_access_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_waddr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ*ADDR_W-1:0] req_raddr1;
    logic [N_REQ*ADDR_W-1:0] req_raddr2;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data1;
    logic [DATA_W-1:0]       rsp_data2;

    modport master (
        output req_valid, req_write, req_waddr, req_wdata, req_raddr1, req_raddr2,
        input  req_ready, rsp_valid, rsp_data1, rsp_data2
    );

    modport slave (
        input  req_valid, req_write, req_waddr, req_wdata, req_raddr1, req_raddr2,
        output req_ready, rsp_valid, rsp_data1, rsp_data2
    );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing one 1W/2R register file among N_REQ requesters.
// Define RF_CLEAR_ON_RESET_EN to zero all 32 registers after every reset.
module regfile_access_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    regfile_access_arbiter_if.slave bus,
    output logic                busy,
    output logic [DATA_W-1:0]   rf_in,
    output logic [ADDR_W-1:0]   rf_select_in,
    output logic [ADDR_W-1:0]   rf_select_out1,
    output logic [ADDR_W-1:0]   rf_select_out2,
    output logic                rf_read,
    output logic                rf_write,
    output logic                rf_enable,
    output logic                rf_reset,
    input  logic [DATA_W-1:0]   rf_out1,
    input  logic [DATA_W-1:0]   rf_out2
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_INIT} state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_grant;
    logic [N_REQ-1:0]    r_rspValid;
    logic [DATA_W-1:0]   r_rspData1;
    logic [DATA_W-1:0]   r_rspData2;
    logic [DATA_W-1:0]   r_rfIn;
    logic [ADDR_W-1:0]   r_selIn;
    logic [ADDR_W-1:0]   r_selOut1;
    logic [ADDR_W-1:0]   r_selOut2;
    logic                r_rfEnable;
    logic                r_rfWrite;
    logic                r_rfRead;

    logic [ADDR_W-1:0]   w_waddr  [N_REQ];
    logic [DATA_W-1:0]   w_wdata  [N_REQ];
    logic [ADDR_W-1:0]   w_raddr1 [N_REQ];
    logic [ADDR_W-1:0]   w_raddr2 [N_REQ];

    logic                w_anyValid;
    logic [PTR_W-1:0]    w_grantIdx;
    logic [PTR_W:0]      w_cand;
    logic [PTR_W-1:0]    w_nextPtr;
    logic                w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_waddr[gi]  = bus.req_waddr[gi*ADDR_W +: ADDR_W];
            assign w_wdata[gi]  = bus.req_wdata[gi*DATA_W +: DATA_W];
            assign w_raddr1[gi] = bus.req_raddr1[gi*ADDR_W +: ADDR_W];
            assign w_raddr2[gi] = bus.req_raddr2[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Scan from the pointer downward in distance so the nearest valid index wins.
    always_comb begin
        w_anyValid = 1'b0;
        w_grantIdx = '0;
        w_cand     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_cand >= (PTR_W+1)'(N_REQ)) begin
                w_cand = w_cand - (PTR_W+1)'(N_REQ);
            end
            if (bus.req_valid[w_cand[PTR_W-1:0]]) begin
                w_anyValid = 1'b1;
                w_grantIdx = w_cand[PTR_W-1:0];
            end
        end
    end

    assign w_nextPtr     = (w_grantIdx == PTR_W'(N_REQ - 1)) ? '0 : w_grantIdx + 1'b1;
    assign w_accept      = (r_state == S_IDLE) && !reset && w_anyValid;
    assign bus.req_ready = w_accept ? (ONE_HOT0 << w_grantIdx) : '0;
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_data1 = r_rspData1;
    assign bus.rsp_data2 = r_rspData2;
    assign busy          = (r_state != S_IDLE) && !reset;
    assign rf_reset      = reset;
    assign rf_select_out1 = r_selOut1;
    assign rf_select_out2 = r_selOut2;
    assign rf_read       = r_rfRead;

`ifdef RF_CLEAR_ON_RESET_EN
    logic [4:0] r_initCnt;
    logic       w_initActive;

    // The clearing sweep overrides the write port without disturbing the held selects.
    assign w_initActive = (r_state == S_INIT) && !reset;
    assign rf_enable    = r_rfEnable | w_initActive;
    assign rf_write     = r_rfWrite | w_initActive;
    assign rf_in        = w_initActive ? '0 : r_rfIn;
    assign rf_select_in = w_initActive ? ADDR_W'(r_initCnt) : r_selIn;
`else
    assign rf_enable    = r_rfEnable;
    assign rf_write     = r_rfWrite;
    assign rf_in        = r_rfIn;
    assign rf_select_in = r_selIn;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
`ifdef RF_CLEAR_ON_RESET_EN
            r_state   <= S_INIT;
            r_initCnt <= '0;
`else
            r_state   <= S_IDLE;
`endif
            r_ptr      <= '0;
            r_grant    <= '0;
            r_rspValid <= '0;
            r_rspData1 <= '0;
            r_rspData2 <= '0;
            r_rfIn     <= '0;
            r_selIn    <= '0;
            r_selOut1  <= '0;
            r_selOut2  <= '0;
            r_rfEnable <= 1'b0;
            r_rfWrite  <= 1'b0;
            r_rfRead   <= 1'b0;
        end else begin
            r_rspValid <= '0;
            r_rfEnable <= 1'b0;
            r_rfWrite  <= 1'b0;
            r_rfRead   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_anyValid) begin
                        r_grant    <= w_grantIdx;
                        r_ptr      <= w_nextPtr;
                        r_rfIn     <= w_wdata[w_grantIdx];
                        r_selIn    <= w_waddr[w_grantIdx];
                        r_selOut1  <= w_raddr1[w_grantIdx];
                        r_selOut2  <= w_raddr2[w_grantIdx];
                        r_rfEnable <= 1'b1;
                        r_rfWrite  <= bus.req_write[w_grantIdx];
                        r_rfRead   <= ~bus.req_write[w_grantIdx];
                        r_state    <= S_ISSUE;
                    end
                end
                // r_rfWrite still carries the latched request type during ISSUE.
                S_ISSUE: begin
                    if (r_rfWrite) begin
                        r_rspValid <= ONE_HOT0 << r_grant;
                        r_state    <= S_IDLE;
                    end else begin
                        r_state    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_rspData1 <= rf_out1;
                    r_rspData2 <= rf_out2;
                    r_rspValid <= ONE_HOT0 << r_grant;
                    r_state    <= S_IDLE;
                end
`ifdef RF_CLEAR_ON_RESET_EN
                S_INIT: begin
                    r_initCnt <= r_initCnt + 5'd1;
                    if (r_initCnt == 5'd31) begin
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Shares the single-write, dual-read 32x32 register file between N_REQ requesters.
- Arbitrates round-robin, sequences each access onto the register-file control pins (enable/write/read/selects/data), and returns read data or a write acknowledgement to the winning requester.
- Sits between the execution/load units and the register file instance.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester request valid
req_write  input  N_REQ  1 = write, 0 = dual read
req_waddr  input  N_REQ*ADDR_W  write address, requester i at bits [i*ADDR_W +: ADDR_W]
req_wdata  input  N_REQ*DATA_W  write data, same packing
req_raddr1  input  N_REQ*ADDR_W  read address port 1
req_raddr2  input  N_REQ*ADDR_W  read address port 2
req_ready  output  N_REQ  one-hot accept, combinational
rsp_valid  output  N_REQ  one-hot, registered 1-cycle completion pulse
rsp_data1  output  DATA_W  registered read data 1
rsp_data2  output  DATA_W  registered read data 2
busy  output  1  high whenever state != IDLE
rf_in  output  DATA_W  to register file write data
rf_select_in  output  ADDR_W  to register file write address
rf_select_out1  output  ADDR_W  to register file read address 1
rf_select_out2  output  ADDR_W  to register file read address 2
rf_read  output  1  register file read strobe
rf_write  output  1  register file write strobe
rf_enable  output  1  register file enable
rf_reset  output  1  equals reset (combinational pass-through)
rf_out1  input  DATA_W  register file read data 1
rf_out2  input  DATA_W  register file read data 2

Behaviour:
- Register file contract:
  - Write commits at the clock edge ending a cycle with rf_enable=1 and rf_write=1.
  - Read data appears on rf_out1/2 the cycle after rf_enable=1 and rf_read=1.
- Reset values: req_ready=0, rsp_valid=0, rsp_data1/2=0, all rf_* registered outputs=0, busy=0, RR pointer=0, state=IDLE (INIT with the optional feature).
- States:
  - IDLE:
    - Grant scan starts at the RR pointer and wraps modulo N_REQ; the first index with req_valid=1 wins.
    - req_ready[g]=1 combinationally. Request fields are latched on that edge. Pointer <= (g+1) mod N_REQ. Next state is ISSUE.
    - With no valid request: req_ready=0 and the state stays IDLE.
  - ISSUE, exactly one cycle:
    - rf_enable=1, rf_write=latched write, rf_read=~latched write.
    - rf_select_in, rf_in, rf_select_out1 and rf_select_out2 come from the latched fields.
    - Write: next state IDLE, and rsp_valid[g]=1 in the following cycle.
    - Read: next state CAPTURE.
  - CAPTURE, one cycle:
    - rf_enable/rf_read=0.
    - rsp_data1/2 <= rf_out1/2 on the edge.
    - rsp_valid[g]=1 in the next cycle. Next state IDLE.
- Outside ISSUE: rf_enable, rf_write and rf_read are 0, and selects/rf_in hold their last values.
- Latency, counted from the accept cycle t:
  - Write acknowledge is at t+2.
  - Read data is valid with rsp_valid at t+3.
  - Back-to-back writes give 1 accept every 2 cycles; back-to-back reads give 1 accept every 3 cycles.
- A new accept is allowed in the same IDLE cycle that rsp_valid pulses for the previous request.
- Handshake:
  - The requester holds valid and its fields stable until req_ready.
  - Dropping valid before grant withdraws the request without side effect.
- rsp_data1/2 hold their value until the next read capture; write acknowledges do not alter them.
- Address 0 is treated like any other address, with no special casing.
- Reset mid-operation: the in-flight request is dropped, no rsp_valid is issued, and the pointer returns to 0. rf_reset asserts the register file reset in the same cycle.

Optional Feature:
RF_CLEAR_ON_RESET_EN
- Defined:
  - After reset deasserts, the state machine enters INIT.
  - A 5-bit counter runs 0..31, one write per cycle: rf_enable=1, rf_write=1, rf_in=0, rf_select_in=counter.
  - During INIT, busy=1 and req_ready=0.
  - After address 31 the state becomes IDLE, 32 cycles after reset release.
- Undefined: there is no INIT state or counter, and reset goes directly to IDLE.

Test Plan:
1. Write then read back:
   - Req0 writes 32'habcdefab to address 1, then reads raddr1=1, raddr2=31.
   - Required: write ack at t+2; read rsp_valid[0] at t+3 with rsp_data1=abcdefab, rsp_data2 = register 31 contents.
2. Round-robin contention:
   - Req0 and req1 hold valid continuously from reset with writes to addresses 2 and 3.
   - Required: grants go 0,1,0,1, and each of req_ready[0] and req_ready[1] is granted exactly once per 4-cycle window.
3. Write/read ordering:
   - Req1 writes 32'h01234567 to address 2; req0's read of address 2 is granted next.
   - Required: rsp_data1=01234567.
4. Withdraw:
   - Req1 asserts valid for 1 cycle while req0 is being serviced, then drops it.
   - Required: req1 is never granted and rf_write never pulses for req1's address.
5. Reset mid-read:
   - Assert reset during CAPTURE.
   - Required: no rsp_valid, busy=0 the next cycle, and the next grant goes to req0.
6. With RF_CLEAR_ON_RESET_EN:
   - Pre-load address 5 with 32'hffffffff, then pulse reset.
   - Required: req_ready=0 for 32 cycles; a later read of address 5 returns 0.
